// File: rtl/rom_read_sequencer_pkg.sv
// Shared types and widths for the ROM read sequencer.
// The owner encoding travels with each in-flight read to route its capture.
package rom_read_sequencer_pkg;

    typedef enum logic {
        OWNER_SCAN = 1'b0,
        OWNER_HOST = 1'b1
    } owner_e;

    // Wait counter only needs to hold RD_LAT-1 with RD_LAT at most 4.
    localparam int unsigned LAT_CNT_W = 2;
    localparam int unsigned SUM_W     = 16;

endpackage

// File: rtl/rom_read_sequencer.sv
// Arbitrates the ROM macro between single-word host reads and a full-space
// checksum scanner; exactly one read is in flight at a time, host first.
module rom_read_sequencer
    import rom_read_sequencer_pkg::*;
#(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rom_en,
    output logic [AW-1:0]    rom_addr,
    input  logic [DW-1:0]    rom_data,
    input  logic             host_req,
    input  logic [AW-1:0]    host_addr,
    output logic             host_ack,
    output logic [DW-1:0]    host_data,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             scan_done,
    output logic [SUM_W-1:0] scan_sum,
    output logic [DW-1:0]    scan_xor
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    state_e               state_q;
    owner_e               owner_q;
    logic [LAT_CNT_W-1:0] wait_cnt_q;
    logic [AW-1:0]        scan_addr_q;
    logic                 rom_en_q;
    logic [AW-1:0]        rom_addr_q;
    logic                 host_ack_q;
    logic [DW-1:0]        host_data_q;
    logic                 scan_busy_q;
    logic                 scan_done_q;
    logic [SUM_W-1:0]     scan_sum_q;
    logic [DW-1:0]        scan_xor_q;

    logic                 host_elig_d;
    logic [SUM_W-1:0]     scan_sum_d;
    logic [DW-1:0]        scan_xor_d;
    logic                 scan_last_d;

    always_comb begin
        host_elig_d = host_req && !host_ack_q;
        scan_sum_d  = scan_sum_q + SUM_W'(rom_data);
        scan_xor_d  = scan_xor_q ^ rom_data;
        scan_last_d = (scan_addr_q == '1);
    end

    // rom_en/rom_addr are loaded on the grant edge so they are valid during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_SCAN;
            wait_cnt_q  <= '0;
            scan_addr_q <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            host_ack_q  <= 1'b0;
            host_data_q <= '0;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
            scan_sum_q  <= '0;
            scan_xor_q  <= '0;
        end else begin
            rom_en_q    <= 1'b0;
            host_ack_q  <= 1'b0;
            scan_done_q <= 1'b0;

            // A scan capture only happens while busy, so this never collides with it.
            if (scan_start && !scan_busy_q) begin
                scan_busy_q <= 1'b1;
                scan_sum_q  <= '0;
                scan_xor_q  <= '0;
                scan_addr_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (host_elig_d) begin
                        owner_q    <= OWNER_HOST;
                        rom_addr_q <= host_addr;
                        rom_en_q   <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end else if (scan_busy_q) begin
                        owner_q    <= OWNER_SCAN;
                        rom_addr_q <= scan_addr_q;
                        rom_en_q   <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_q <= LAT_LOAD;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        if (owner_q == OWNER_HOST) begin
                            host_data_q <= rom_data;
                            host_ack_q  <= 1'b1;
                        end else begin
                            scan_sum_q  <= scan_sum_d;
                            scan_xor_q  <= scan_xor_d;
                            scan_addr_q <= scan_addr_q + 1'b1;
                            if (scan_last_d) begin
                                scan_busy_q <= 1'b0;
                                scan_done_q <= 1'b1;
                            end
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign host_ack  = host_ack_q;
    assign host_data = host_data_q;
    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;
    assign scan_sum  = scan_sum_q;
    assign scan_xor  = scan_xor_q;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: ROM model returns addr ^ 0xA5; expected host
// data and scan results are queued at stimulus time and checked by monitors.
module tb_rom_read_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: RD_LAT = 1
    logic        rst_a;
    logic        rom_en_a;
    logic [7:0]  rom_addr_a;
    logic [7:0]  rom_data_a;
    logic        host_req_a;
    logic [7:0]  host_addr_a;
    logic        host_ack_a;
    logic [7:0]  host_data_a;
    logic        scan_start_a;
    logic        scan_busy_a;
    logic        scan_done_a;
    logic [15:0] scan_sum_a;
    logic [7:0]  scan_xor_a;

    // Instance B: RD_LAT = 3
    logic        rst_b;
    logic        rom_en_b;
    logic [7:0]  rom_addr_b;
    logic [7:0]  rom_data_b;
    logic        host_req_b;
    logic [7:0]  host_addr_b;
    logic        host_ack_b;
    logic [7:0]  host_data_b;
    logic        scan_start_b;
    logic        scan_busy_b;
    logic        scan_done_b;
    logic [15:0] scan_sum_b;
    logic [7:0]  scan_xor_b;

    rom_read_sequencer #(.AW(8), .DW(8), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .host_req(host_req_a), .host_addr(host_addr_a),
        .host_ack(host_ack_a), .host_data(host_data_a), .scan_start(scan_start_a),
        .scan_busy(scan_busy_a), .scan_done(scan_done_a), .scan_sum(scan_sum_a),
        .scan_xor(scan_xor_a)
    );

    rom_read_sequencer #(.AW(8), .DW(8), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .host_req(host_req_b), .host_addr(host_addr_b),
        .host_ack(host_ack_b), .host_data(host_data_b), .scan_start(scan_start_b),
        .scan_busy(scan_busy_b), .scan_done(scan_done_b), .scan_sum(scan_sum_b),
        .scan_xor(scan_xor_b)
    );

    // ROM models: data valid only RD_LAT cycles after the strobe, junk otherwise.
    always @(posedge clk) rom_data_a <= rom_en_a ? (rom_addr_a ^ 8'hA5) : 8'hEE;

    logic [7:0] pipe_b1, pipe_b2;
    always @(posedge clk) begin
        pipe_b1    <= rom_en_b ? (rom_addr_b ^ 8'hA5) : 8'hEE;
        pipe_b2    <= pipe_b1;
        rom_data_b <= pipe_b2;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboards
    logic [7:0]  host_q_a[$];
    logic [7:0]  host_q_b[$];
    logic [23:0] scan_q[$];

    always @(negedge clk) begin
        if (host_ack_a) begin
            if (host_q_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL host_a unexpected ack: got data 0x%0h, expected no ack", host_data_a);
            end else begin
                chk("host_a data", 64'(host_data_a), 64'(host_q_a.pop_front()));
            end
        end
        if (host_ack_b) begin
            if (host_q_b.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL host_b unexpected ack: got data 0x%0h, expected no ack", host_data_b);
            end else begin
                chk("host_b data", 64'(host_data_b), 64'(host_q_b.pop_front()));
            end
        end
        if (scan_done_a) begin
            if (scan_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL scan unexpected done: got sum 0x%0h xor 0x%0h, expected no done",
                         scan_sum_a, scan_xor_a);
            end else begin
                chk("scan sum/xor at done", 64'({scan_sum_a, scan_xor_a}), 64'(scan_q.pop_front()));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        scan_start_a = 1'b1;
        @(posedge clk);
        #1;
        scan_start_a = 1'b0;
    endtask

    task automatic host_read_a(input logic [7:0] a);
        int t;
        host_q_a.push_back(a ^ 8'hA5);
        host_req_a  = 1'b1;
        host_addr_a = a;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!host_ack_a && t < 100);
        if (!host_ack_a) begin
            n_vec++; n_err++;
            $display("FAIL host_a ack timeout: got no ack in %0d cycles, expected ack", t);
            void'(host_q_a.pop_front());
        end
        @(posedge clk);
        #1;
        host_req_a = 1'b0;
    endtask

    int ws_busy, ws_en, ws_done, ws_bad;

    task automatic wait_scan(input bit check_addr);
        int t;
        logic [7:0] exp_a;
        ws_busy = 0; ws_en = 0; ws_done = 0; ws_bad = 0;
        exp_a = 8'h00;
        t = 0;
        while (ws_done == 0 && t < 4000) begin
            @(negedge clk);
            t++;
            if (scan_busy_a) ws_busy++;
            if (rom_en_a) begin
                ws_en++;
                if (check_addr) begin
                    if (rom_addr_a != exp_a) ws_bad++;
                    exp_a = exp_a + 8'h01;
                end
            end
            if (scan_done_a) ws_done = 1;
        end
        if (ws_done == 0) begin
            n_vec++; n_err++;
            $display("FAIL scan_done timeout: got no done in %0d cycles, expected done", t);
        end
    endtask

    task automatic check_quiet_after_done(input string name);
        int extra;
        int busy_seen;
        extra = 0;
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (scan_done_a) extra++;
            if (scan_busy_a) busy_seen++;
        end
        chk({name, " extra done"}, 64'(extra), 64'(0));
        chk({name, " busy after done"}, 64'(busy_seen), 64'(0));
        chk({name, " sum/xor held"}, 64'({scan_sum_a, scan_xor_a}), 64'h7F80_00);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        int ack_n;
        int ack_cyc[6];
        int clash;
        int bad_cnt;
        int t;

        rst_a = 1'b1; host_req_a = 1'b0; host_addr_a = '0; scan_start_a = 1'b0;
        rst_b = 1'b1; host_req_b = 1'b0; host_addr_b = '0; scan_start_b = 1'b0;
        cycles(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("reset A outputs", 64'({rom_en_a, rom_addr_a, host_ack_a, host_data_a, scan_busy_a,
                                    scan_done_a, scan_sum_a, scan_xor_a}), 64'h0);
        chk("reset B outputs", 64'({rom_en_b, rom_addr_b, host_ack_b, host_data_b, scan_busy_b,
                                    scan_done_b, scan_sum_b, scan_xor_b}), 64'h0);
        cycles(2);

        // Host read latency: req rises at T, rom_en only at T+1, ack at T+3
        host_q_a.push_back(8'h99);
        host_req_a  = 1'b1;
        host_addr_a = 8'h3C;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("host lat rom_en k=%0d", k), 64'(rom_en_a), 64'(k == 1));
            chk($sformatf("host lat ack k=%0d", k), 64'(host_ack_a), 64'(k == 3));
            if (k == 1) chk("host lat rom_addr", 64'(rom_addr_a), 64'h3C);
            if (k == 3) begin
                @(posedge clk);
                #1;
                host_req_a = 1'b0;
            end
        end
        host_read_a(8'h00);
        host_read_a(8'hFF);
        host_read_a(8'h5A);
        cycles(3);

        // Plain scan
        scan_q.push_back(24'h7F80_00);
        pulse_start();
        wait_scan(1'b1);
        chk("scan busy cycles", 64'(ws_busy), 64'(768));
        chk("scan rom_en count", 64'(ws_en), 64'(256));
        chk("scan address order errors", 64'(ws_bad), 64'(0));
        check_quiet_after_done("scan");

        // Scan with host reads every 20 cycles: each host read stalls it 3 cycles
        scan_q.push_back(24'h7F80_00);
        pulse_start();
        fork
            wait_scan(1'b0);
            begin
                for (int i = 0; i < 10; i++) begin
                    cycles(20);
                    host_read_a(8'(i * 23 + 7));
                end
            end
        join
        chk("scan+host busy cycles", 64'(ws_busy), 64'(768 + 30));
        chk("scan+host rom_en count", 64'(ws_en), 64'(266));
        check_quiet_after_done("scan+host");

        // Mid-scan start pulse is ignored
        scan_q.push_back(24'h7F80_00);
        pulse_start();
        fork
            wait_scan(1'b1);
            begin
                cycles(300);
                pulse_start();
            end
        join
        chk("restart busy cycles", 64'(ws_busy), 64'(768));
        chk("restart rom_en count", 64'(ws_en), 64'(256));
        chk("restart address order errors", 64'(ws_bad), 64'(0));
        check_quiet_after_done("restart");

        // Reset while scan read 100 is in flight
        pulse_start();
        t = 0;
        while (!(rom_en_a && rom_addr_a == 8'd100) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("reach scan read 100", 64'(rom_en_a && rom_addr_a == 8'd100), 64'(1));
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("mid-read reset outputs", 64'({rom_en_a, rom_addr_a, host_ack_a, host_data_a, scan_busy_a,
                                           scan_done_a, scan_sum_a, scan_xor_a}), 64'h0);
        bad_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rom_en_a || host_ack_a || scan_done_a) bad_cnt++;
        end
        chk("post-reset activity", 64'(bad_cnt), 64'(0));
        cycles(1);
        scan_q.push_back(24'h7F80_00);
        pulse_start();
        wait_scan(1'b1);
        chk("post-reset scan busy cycles", 64'(ws_busy), 64'(768));
        chk("post-reset scan address errors", 64'(ws_bad), 64'(0));
        check_quiet_after_done("post-reset scan");

        // RD_LAT=3, host_req held: ack at T+5, then one ack per 6 cycles since
        // the ack cycle itself is not eligible for a new grant
        for (int i = 0; i < 6; i++) host_q_b.push_back(8'hA5);
        host_req_b  = 1'b1;
        host_addr_b = 8'h00;
        t0 = cyc;
        ack_n = 0;
        clash = 0;
        t = 0;
        while (ack_n < 6 && t < 200) begin
            @(negedge clk);
            t++;
            if (rom_en_b && host_ack_b) clash++;
            if (host_ack_b) begin
                ack_cyc[ack_n] = cyc;
                ack_n++;
            end
        end
        @(posedge clk);
        #1;
        host_req_b = 1'b0;
        chk("lat3 ack count", 64'(ack_n), 64'(6));
        chk("lat3 read in ack cycle", 64'(clash), 64'(0));
        if (ack_n == 6) begin
            chk("lat3 first ack latency", 64'(ack_cyc[0] - t0), 64'(5));
            for (int i = 1; i < 6; i++)
                chk($sformatf("lat3 ack interval %0d", i), 64'(ack_cyc[i] - ack_cyc[i-1]), 64'(6));
        end
        cycles(10);
        chk("lat3 quiet after release", 64'({rom_en_b, host_ack_b}), 64'h0);

        chk("host_a queue drained", 64'(host_q_a.size()), 64'(0));
        chk("host_b queue drained", 64'(host_q_b.size()), 64'(0));
        chk("scan queue drained", 64'(scan_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
